// File: rtl/uart_pkg.sv
// Shared event byte codes and hold-FSM state type for the button event encoder.
package uart_pkg;

  localparam logic [7:0] EVT_PRESS   = 8'h50;
  localparam logic [7:0] EVT_RELEASE = 8'h52;
  localparam logic [7:0] EVT_LONG    = 8'h4C;

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StLongSent
  } hold_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head; a pop frees space for a push on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/button_event_encoder.sv
// Turns debounced button edges into queued ASCII event bytes for a UART transmitter.
// Define BUTTON_LONG_PRESS_EN to add the hold counter and 'L' long-press events.
module button_event_encoder
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned LONG_PRESS_CC = 1000
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic        button_db,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        overflow,
  output logic [15:0] press_count
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (LONG_PRESS_CC < 2) begin : g_bad_hold
    $error("LONG_PRESS_CC must be at least 2");
  end

  logic        button_prev_q;
  logic        press, rel;
  logic        long_hit, long_evt;
  logic        evt_valid;
  logic [7:0]  evt_byte;
  logic        fifo_full, fifo_empty, pop;
  logic [7:0]  fifo_head;
  logic        overflow_q;
  logic [15:0] press_count_q;
  hold_state_e state_q, state_d;

  assign press = button_db & ~button_prev_q;
  assign rel   = ~button_db & button_prev_q;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned CntW = $clog2(LONG_PRESS_CC);
  logic [CntW-1:0] hold_cnt_q;

  assign long_hit = (hold_cnt_q == CntW'(LONG_PRESS_CC - 1));

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      hold_cnt_q <= '0;
    end else if (state_q == StIdle && press) begin
      hold_cnt_q <= '0;
    end else if (state_q == StHeld) begin
      hold_cnt_q <= hold_cnt_q + 1'b1;
    end
  end
`else
  assign long_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Release wins over the hold threshold on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (press) state_d = StHeld;
      StHeld: begin
        if (rel)           state_d = StIdle;
        else if (long_hit) state_d = StLongSent;
      end
      StLongSent: if (rel) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    long_evt = (state_q == StHeld) && (state_d == StLongSent);
  end

  always_comb begin
    evt_valid = 1'b1;
    evt_byte  = 8'h00;
    if (press)         evt_byte = EVT_PRESS;
    else if (rel)      evt_byte = EVT_RELEASE;
    else if (long_evt) evt_byte = EVT_LONG;
    else               evt_valid = 1'b0;
  end

  assign pop = ~fifo_empty & tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .RSTn  (RSTn),
    .push  (evt_valid),
    .pop   (pop),
    .wdata (evt_byte),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      button_prev_q <= 1'b1;
      overflow_q    <= 1'b0;
      press_count_q <= '0;
    end else begin
      button_prev_q <= button_db;
      overflow_q    <= overflow_q | (evt_valid & fifo_full & ~pop);
      if (press) press_count_q <= press_count_q + 16'd1;
    end
  end

  assign tx_valid    = ~fifo_empty;
  assign tx_data     = fifo_empty ? 8'h00 : fifo_head;
  assign overflow    = overflow_q;
  assign press_count = press_count_q;

endmodule

// File: doc/button_event_encoder.md
BUTTON_EVENT_ENCODER -- requirements
Module: button_event_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event queue depth (power of two, ≥2).
REQ-002 SHALL have parameter LONG_PRESS_CC, default 1000, hold cycles before a long-press event (≥2).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port button_db  input  1  debounced button level from the upstream debouncer, synchronous to clk.
REQ-006 SHALL have port tx_ready  input  1  UART transmitter accepts a byte this cycle.
REQ-007 SHALL have port tx_valid  output  1  tx_data holds a pending event byte.
REQ-008 SHALL have port tx_data  output  8  ASCII event code.
REQ-009 SHALL have port overflow  output  1  sticky flag: at least one event was dropped.
REQ-010 SHALL have port press_count  output  16  number of detected presses, wraps.

Function
REQ-011 SHALL register button_db into button_prev each cycle; press = button_db & ~button_prev, release = ~button_db & button_prev.
REQ-012 SHALL push 8'h50 ('P') into the FIFO on the same clock edge at which press is seen, and 8'h52 ('R') on release.
REQ-013 SHALL assert tx_valid in the cycle after the push when the FIFO was empty (one-cycle latency), with tx_data = head entry.
REQ-014 SHALL pop the head on a clock edge where tx_valid & tx_ready; tx_data/tx_valid SHALL stay stable while tx_valid & ~tx_ready.
REQ-015 SHALL, when full, drop the new event and set overflow, unless a pop occurs on the same edge, in which case the push is accepted and occupancy is unchanged.
REQ-016 SHALL, when empty, deassert tx_valid; a simultaneous push into an empty FIFO SHALL NOT bypass to tx_data in the same cycle.
REQ-017 SHALL increment press_count by 1 on every press, including presses whose event was dropped; 16'hFFFF wraps to 0.
REQ-018 SHALL run hold FSM states IDLE, HELD, LONG_SENT: IDLE->HELD on press; HELD->LONG_SENT when hold counter = LONG_PRESS_CC-1; HELD/LONG_SENT->IDLE on release.
REQ-019 SHALL clear the hold counter on entry to HELD, increment it each cycle in HELD, and hold it in IDLE/LONG_SENT.
REQ-020 SHALL give release priority over the threshold when both occur on the same edge (go to IDLE, no long-press event).
REQ-021 SHALL generate at most one event per cycle; the FSM in IDLE on reset exit with button_db=1 SHALL NOT generate a press.

Reset
REQ-022 SHALL, on RSTn low, asynchronously clear FIFO pointers and occupancy, tx_valid=0, tx_data=8'h00, overflow=0, press_count=0, hold counter=0, FSM=IDLE, button_prev=1.
REQ-023 SHALL discard all queued events on reset mid-operation; overflow SHALL be cleared only by reset.

Configuration
REQ-024 SHALL, with BUTTON_LONG_PRESS_EN defined, push 8'h4C ('L') on the HELD->LONG_SENT transition (dropped/overflow rules as REQ-015).
REQ-025 SHALL, without BUTTON_LONG_PRESS_EN, never leave HELD except on release, omit the hold counter, and never emit 'L'.

Structure
REQ-026 SHALL take EVT_PRESS, EVT_RELEASE, EVT_LONG byte constants and the hold FSM state enum from shared package uart_pkg.
REQ-027 SHALL implement the queue as one sub-module sync_fifo (parameterised width/depth, push/pop/full/empty, async active-low reset).

Verification
REQ-028 SHALL check press with tx_ready=1: button_db 0->1 at edge k -> tx_valid=1, tx_data=8'h50 after edge k, popped at edge k+1, press_count=1.
REQ-029 SHALL check backpressure: tx_ready=0, 5 press/release edges, FIFO_DEPTH=4 -> 'P','R','P','R' queued, overflow=1, then tx_ready=1 drains exactly 4 bytes in order.
REQ-030 SHALL check full+pop same edge: FIFO full, tx_ready=1 and release on same edge -> push accepted, overflow stays 0.
REQ-031 SHALL check long press (macro on, LONG_PRESS_CC=8): hold 20 cycles -> sequence 'P','L','R'; release at hold counter 7 -> 'P','R' only.
REQ-032 SHALL check macro off: hold 2000 cycles -> only 'P','R'.
REQ-033 SHALL check reset mid-operation: 3 queued events, RSTn pulsed low -> tx_valid=0, overflow=0, press_count=0 immediately, no press generated with button_db held 1.
